// File: rtl/reg_access_master.sv
// reg_access_master
//   Turns one register-access command (read rs1, read rs2, optional write rd)
//   into a sequence of single-beat register-file bus transactions and
//   returns both read operands plus a timeout flag.
//
// Ports
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_req_*, o_req_ready    command handshake and fields
//   o_rsp_*, i_rsp_ready    response handshake, operands, timeout error
//   o_wb_*                  bus strobe, write enable, address, write data
//   i_wb_data/ack/stall     bus read data, acknowledge, stall
module reg_access_master #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [4:0]  i_req_rs1,
    input  logic [4:0]  i_req_rs2,
    input  logic [4:0]  i_req_rd,
    input  logic        i_req_rd_we,
    input  logic [31:0] i_req_rd_data,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rs1_data,
    output logic [31:0] o_rsp_rs2_data,
    output logic        o_rsp_err,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall
);

    typedef enum logic [2:0] {
        IDLE, RD1_ISSUE, RD1_WAIT, RD2_ISSUE, RD2_WAIT, WR_ISSUE, WR_WAIT, RESP
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic        wr_q;
    logic [31:0] wdata_q;

    state_t      first_step;
    state_t      after_rd1;
    state_t      after_rd2;
    logic        req_wr;

    // Zero-index reads and suppressed writes are skipped when choosing the next step.
    always_comb begin
        req_wr     = i_req_rd_we && (i_req_rd != '0);
        after_rd2  = wr_q ? WR_ISSUE : RESP;
        after_rd1  = (rs2_q != '0) ? RD2_ISSUE : after_rd2;
        first_step = RESP;
        if (i_req_rs1 != '0)
            first_step = RD1_ISSUE;
        else if (i_req_rs2 != '0)
            first_step = RD2_ISSUE;
        else if (req_wr)
            first_step = WR_ISSUE;
    end

    assign o_req_ready = (state == IDLE);
    assign o_rsp_valid = (state == RESP);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            rd_q           <= '0;
            wr_q           <= 1'b0;
            wdata_q        <= '0;
            o_rsp_rs1_data <= '0;
            o_rsp_rs2_data <= '0;
            o_rsp_err      <= 1'b0;
            o_wb_stb       <= 1'b0;
            o_wb_we        <= 1'b0;
            o_wb_addr      <= '0;
            o_wb_data      <= '0;
        end else begin
            o_wb_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        rs1_q   <= i_req_rs1;
                        rs2_q   <= i_req_rs2;
                        rd_q    <= i_req_rd;
                        wr_q    <= req_wr;
                        wdata_q <= i_req_rd_data;
                        // Operands start at zero so skipped or aborted reads need no extra clearing.
                        o_rsp_rs1_data <= '0;
                        o_rsp_rs2_data <= '0;
                        o_rsp_err      <= 1'b0;
                        state          <= first_step;
                    end
                end
                RD1_ISSUE: begin
                    if (!i_wb_stall) begin
                        o_wb_stb  <= 1'b1;
                        o_wb_we   <= 1'b0;
                        o_wb_addr <= {27'b0, rs1_q};
                        o_wb_data <= '0;
                        wait_cnt  <= '0;
                        state     <= RD1_WAIT;
                    end
                end
                RD1_WAIT: begin
                    if (i_wb_ack) begin
                        o_rsp_rs1_data <= i_wb_data;
                        state          <= after_rd1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        o_rsp_err <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RD2_ISSUE: begin
                    if (!i_wb_stall) begin
                        o_wb_stb  <= 1'b1;
                        o_wb_we   <= 1'b0;
                        o_wb_addr <= {27'b0, rs2_q};
                        o_wb_data <= '0;
                        wait_cnt  <= '0;
                        state     <= RD2_WAIT;
                    end
                end
                RD2_WAIT: begin
                    if (i_wb_ack) begin
                        o_rsp_rs2_data <= i_wb_data;
                        state          <= after_rd2;
                    end else if (wait_cnt == WAIT_LAST) begin
                        o_rsp_err <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WR_ISSUE: begin
                    if (!i_wb_stall) begin
                        o_wb_stb  <= 1'b1;
                        o_wb_we   <= 1'b1;
                        o_wb_addr <= {27'b0, rd_q};
                        o_wb_data <= wdata_q;
                        wait_cnt  <= '0;
                        state     <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (i_wb_ack) begin
                        state <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        o_rsp_err <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_master.sv
// Testbench for reg_access_master.
// Latency convention: the acceptance edge counts as cycle 1. A command with
// no bus work shows o_rsp_valid in cycle 1. With three transactions and a
// slave that acks in the same cycle the strobe is high (ack seen on the first
// wait edge), each transaction costs two edges (issue, ack), so o_rsp_valid
// appears in cycle 1 + 3*2 = 7.
module tb_reg_access_master;

    localparam int TMO = 15;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [4:0]  i_req_rs1, i_req_rs2, i_req_rd;
    logic        i_req_rd_we;
    logic [31:0] i_req_rd_data;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rs1_data, o_rsp_rs2_data;
    logic        o_rsp_err;
    logic        o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic [31:0] i_wb_data;
    logic        i_wb_ack;
    logic        i_wb_stall;

    reg_access_master #(.TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_rs1(i_req_rs1), .i_req_rs2(i_req_rs2), .i_req_rd(i_req_rd),
        .i_req_rd_we(i_req_rd_we), .i_req_rd_data(i_req_rd_data),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rs1_data(o_rsp_rs1_data), .o_rsp_rs2_data(o_rsp_rs2_data),
        .o_rsp_err(o_rsp_err),
        .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .i_wb_data(i_wb_data), .i_wb_ack(i_wb_ack),
        .i_wb_stall(i_wb_stall)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } op_t;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic [31:0] data;
        int          lat;
        int          nack;
        logic [31:0] e1, e2;
        logic        eerr;
        int          nops;
    } vec_t;

    // Register file contents seen by the slave (owned by the main thread).
    logic [31:0] mem [32];
    op_t         obs [$];
    op_t         exp_ops [$];
    int          obs_base = 0;
    int          ack_lat = 0;
    int          nack_from = 99;

    int passed = 0;
    int total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Slave: logs every strobe and returns ack ack_lat cycles later
    // (0 = ack in the strobe cycle); ops at index >= nack_from never ack.
    initial begin : slave
        int          cnt;
        bit          pend;
        logic [31:0] paddr;
        logic        pwe;
        int          idx;
        pend = 0; cnt = 0; paddr = '0; pwe = 0;
        i_wb_ack = 1'b0;
        i_wb_data = '0;
        forever begin
            @(posedge i_clk); #1;
            i_wb_ack = 1'b0;
            i_wb_data = '0;
            if (o_wb_stb) begin
                obs.push_back('{o_wb_addr, o_wb_we, o_wb_data});
                idx = obs.size() - 1 - obs_base;
                if (ack_lat >= 0 && idx < nack_from) begin
                    pend = 1; cnt = ack_lat; paddr = o_wb_addr; pwe = o_wb_we;
                end
            end
            if (pend) begin
                if (cnt == 0) begin
                    i_wb_ack = 1'b1;
                    i_wb_data = pwe ? 32'h0 : mem[paddr[4:0]];
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic check_reset_vals(input string p);
        check({p, "_req_ready"}, {31'b0, o_req_ready}, 32'd1);
        check({p, "_rsp_valid"}, {31'b0, o_rsp_valid}, 32'd0);
        check({p, "_rsp_err"},   {31'b0, o_rsp_err},   32'd0);
        check({p, "_rs1_data"},  o_rsp_rs1_data, 32'd0);
        check({p, "_rs2_data"},  o_rsp_rs2_data, 32'd0);
        check({p, "_wb_stb"},    {31'b0, o_wb_stb}, 32'd0);
        check({p, "_wb_we"},     {31'b0, o_wb_we},  32'd0);
        check({p, "_wb_addr"},   o_wb_addr, 32'd0);
        check({p, "_wb_data"},   o_wb_data, 32'd0);
    endtask

    // Bus operations the command must produce, in order.
    task automatic build_exp(input logic [4:0] rs1, rs2, rd, input logic we, input logic [31:0] d);
        exp_ops.delete();
        if (rs1 != 0) exp_ops.push_back('{{27'b0, rs1}, 1'b0, 32'h0});
        if (rs2 != 0) exp_ops.push_back('{{27'b0, rs2}, 1'b0, 32'h0});
        if (we && rd != 0) exp_ops.push_back('{{27'b0, rd}, 1'b1, d});
    endtask

    task automatic accept(input logic [4:0] rs1, rs2, rd, input logic we, input logic [31:0] d);
        obs_base = obs.size();
        build_exp(rs1, rs2, rd, we, d);
        i_req_valid = 1'b1;
        i_req_rs1 = rs1; i_req_rs2 = rs2; i_req_rd = rd;
        i_req_rd_we = we; i_req_rd_data = d;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        // Scramble fields to prove they were captured at acceptance.
        i_req_rs1 = 5'($urandom); i_req_rs2 = 5'($urandom); i_req_rd = 5'($urandom);
        i_req_rd_we = 1'($urandom); i_req_rd_data = $urandom;
    endtask

    task automatic wait_rsp(input string name, output int lat);
        lat = 1;
        while (!o_rsp_valid && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
        end
        check({name, "_rsp_arrived"}, {31'b0, o_rsp_valid}, 32'd1);
    endtask

    task automatic check_ops(input string name, input int nops);
        check({name, "_nops"}, 32'(obs.size() - obs_base), 32'(nops));
        for (int i = 0; i < nops && obs_base + i < obs.size() && i < exp_ops.size(); i++) begin
            check($sformatf("%s_op%0d_addr", name, i), obs[obs_base + i].addr, exp_ops[i].addr);
            check($sformatf("%s_op%0d_we", name, i), {31'b0, obs[obs_base + i].we}, {31'b0, exp_ops[i].we});
            check($sformatf("%s_op%0d_data", name, i), obs[obs_base + i].data, exp_ops[i].data);
        end
    endtask

    task automatic run_txn(input string name, input logic [4:0] rs1, rs2, rd, input logic we,
                           input logic [31:0] d, input logic [31:0] e1, e2, input logic eerr,
                           input int nops, output int lat);
        if (o_req_ready !== 1'b1) check({name, "_idle_before"}, {31'b0, o_req_ready}, 32'd1);
        accept(rs1, rs2, rd, we, d);
        wait_rsp(name, lat);
        check({name, "_rs1"}, o_rsp_rs1_data, e1);
        check({name, "_rs2"}, o_rsp_rs2_data, e2);
        check({name, "_err"}, {31'b0, o_rsp_err}, {31'b0, eerr});
        check_ops(name, nops);
        if (!eerr && we && rd != 0) mem[rd] = d;
        if (i_rsp_ready) begin
            @(posedge i_clk); #1;
        end
    endtask

    vec_t vecs [10];

    initial begin : main
        int lat;
        logic [4:0]  r1, r2, rdx;
        logic        w;
        logic [31:0] d, e1, e2;
        logic        eerr;
        int          nops, n0;
        bit          noack;

        vecs[0] = '{5'd5, 5'd6, 5'd9, 1'b0, 32'h0,        0, 99, 32'h11,       32'h22,       1'b0, 2};
        vecs[1] = '{5'd3, 5'd0, 5'd3, 1'b1, 32'hDEADBEEF, 0, 99, 32'h7,        32'h0,        1'b0, 2};
        vecs[2] = '{5'd3, 5'd3, 5'd0, 1'b1, 32'h1234,     1, 99, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2};
        vecs[3] = '{5'd0, 5'd0, 5'd7, 1'b0, 32'h5555,     0, 99, 32'h0,        32'h0,        1'b0, 0};
        vecs[4] = '{5'd0, 5'd0, 5'd0, 1'b1, 32'h6666,     0, 99, 32'h0,        32'h0,        1'b0, 0};
        vecs[5] = '{5'd5, 5'd5, 5'd5, 1'b1, 32'hCAFE0005, 2, 99, 32'h11,       32'h11,       1'b0, 3};
        vecs[6] = '{5'd6, 5'd7, 5'd8, 1'b1, 32'h8888,     1, 1,  32'h22,       32'h0,        1'b1, 2};
        vecs[7] = '{5'd6, 5'd0, 5'd0, 1'b0, 32'h0,        TMO - 1, 99, 32'h22, 32'h0,        1'b0, 1};
        vecs[8] = '{5'd6, 5'd0, 5'd0, 1'b0, 32'h0,        TMO, 99, 32'h0,      32'h0,        1'b1, 1};
        vecs[9] = '{5'd0, 5'd6, 5'd0, 1'b1, 32'h9999,     3, 99, 32'h0,        32'h22,       1'b0, 1};

        for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[3] = 32'h7; mem[5] = 32'h11; mem[6] = 32'h22;

        i_reset_n = 1'b0;
        i_req_valid = 1'b0; i_req_rs1 = '0; i_req_rs2 = '0; i_req_rd = '0;
        i_req_rd_we = 1'b0; i_req_rd_data = '0;
        i_rsp_ready = 1'b1; i_wb_stall = 1'b0;
        #3;
        check_reset_vals("rst_async");
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        check_reset_vals("rst_idle");

        // Table-driven directed vectors.
        for (int i = 0; i < 10; i++) begin
            ack_lat = vecs[i].lat;
            nack_from = vecs[i].nack;
            run_txn($sformatf("vec%0d", i), vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].we,
                    vecs[i].data, vecs[i].e1, vecs[i].e2, vecs[i].eerr, vecs[i].nops, lat);
            if (i == 3) check("vec3_nobus_latency", 32'(lat), 32'd1);
        end
        nack_from = 99;

        // Minimum latency with three transactions.
        ack_lat = 0;
        run_txn("lat3", 5'd1, 5'd2, 5'd4, 1'b1, 32'h4444_0004, mem[1], mem[2], 1'b0, 3, lat);
        check("lat3_latency", 32'(lat), 32'd7);

        // Stall held four cycles in the first issue state.
        ack_lat = 0;
        i_wb_stall = 1'b1;
        accept(5'd5, 5'd6, 5'd0, 1'b0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(posedge i_clk); #1;
            check($sformatf("stall_c%0d_stb", c), {31'b0, o_wb_stb}, 32'd0);
            check($sformatf("stall_c%0d_ready", c), {31'b0, o_req_ready}, 32'd0);
        end
        i_wb_stall = 1'b0;
        wait_rsp("stall", lat);
        check("stall_rs1", o_rsp_rs1_data, mem[5]);
        check("stall_rs2", o_rsp_rs2_data, 32'h22);
        check_ops("stall", 2);
        @(posedge i_clk); #1;

        // Response held while i_rsp_ready is low.
        i_rsp_ready = 1'b0;
        accept(5'd6, 5'd3, 5'd0, 1'b0, 32'h0);
        wait_rsp("hold", lat);
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk); #1;
            check($sformatf("hold_c%0d_valid", c), {31'b0, o_rsp_valid}, 32'd1);
            check($sformatf("hold_c%0d_rs1", c), o_rsp_rs1_data, 32'h22);
            check($sformatf("hold_c%0d_rs2", c), o_rsp_rs2_data, 32'hDEADBEEF);
            check($sformatf("hold_c%0d_ready", c), {31'b0, o_req_ready}, 32'd0);
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        check("hold_release_valid", {31'b0, o_rsp_valid}, 32'd0);
        check("hold_release_ready", {31'b0, o_req_ready}, 32'd1);

        // Reset pulse during the second read's wait, ack arrives afterwards.
        ack_lat = 3;
        accept(5'd5, 5'd6, 5'd9, 1'b1, 32'h7777);
        n0 = 0;
        while (!(o_wb_stb && o_wb_addr == 32'd6) && n0 < 20) begin
            @(posedge i_clk); #1;
            n0++;
        end
        check("rstmid_rd2_issued", o_wb_addr, 32'd6);
        i_reset_n = 1'b0;
        #2;
        check_reset_vals("rstmid_async");
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        n0 = obs.size();
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk); #1;
            check($sformatf("rstmid_c%0d_stb", c), {31'b0, o_wb_stb}, 32'd0);
            check($sformatf("rstmid_c%0d_valid", c), {31'b0, o_rsp_valid}, 32'd0);
            check($sformatf("rstmid_c%0d_ready", c), {31'b0, o_req_ready}, 32'd1);
        end
        check("rstmid_no_bus", 32'(obs.size() - n0), 32'd0);
        check_reset_vals("rstmid_after");

        // Randomized commands against the reference model.
        for (int t = 0; t < 40; t++) begin
            r1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r2  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rdx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            w   = 1'($urandom);
            d   = $urandom;
            noack = ($urandom_range(0, 7) == 0);
            ack_lat = $urandom_range(0, 3);
            nack_from = noack ? 0 : 99;
            build_exp(r1, r2, rdx, w, d);
            e1 = (r1 != 0) ? mem[r1] : 32'h0;
            e2 = (r2 != 0) ? mem[r2] : 32'h0;
            eerr = 1'b0;
            nops = exp_ops.size();
            if (noack && nops > 0) begin
                e1 = 32'h0; e2 = 32'h0; eerr = 1'b1; nops = 1;
            end
            run_txn($sformatf("rnd%0d", t), r1, r2, rdx, w, d, e1, e2, eerr, nops, lat);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
